// File: rtl/aha_ahb_pkg.sv
// Shared AHB-Lite definitions: transfer encodings, size codes and byte-strobe generation
// for the 64-bit SRAM controller.
package aha_ahb_pkg;

    localparam int ADDR_WIDTH = 15;
    localparam int SRAM_AW    = 12;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Lanes touched by a transfer; sizes of a dword or larger cover the whole word.
    function automatic logic [7:0] ahb_byte_strb(input logic [2:0] size, input logic [2:0] addr);
        case (size)
            HSIZE_BYTE: return 8'h01 << addr;
            HSIZE_HALF: return 8'h03 << {addr[2:1], 1'b0};
            HSIZE_WORD: return 8'h0F << {addr[2], 2'b00};
            default:    return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_4kx64_ctrl_if.sv
// AHB-Lite bus bundle for the SRAM controller; the master side drives requests and
// write data, the slave side returns ready, response and read data.
interface ahb_sram_4kx64_ctrl_if;
    import aha_ahb_pkg::*;

    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic                  HREADY;
    logic [63:0]           HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [63:0]           HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_sram_wbuf.sv
// Single-entry posted-write buffer; holds one word with its byte strobe until the SRAM
// port is free, and reports which of its bytes overlay a read of a given word.
module ahb_sram_wbuf
    import aha_ahb_pkg::*;
(
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               i_load,
    input  logic [SRAM_AW-1:0] i_load_addr,
    input  logic [7:0]         i_load_strb,
    input  logic [63:0]        i_load_data,
    input  logic               i_commit,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic               o_valid,
    output logic [SRAM_AW-1:0] o_addr,
    output logic [7:0]         o_strb,
    output logic [63:0]        o_data,
    output logic [7:0]         o_fwd_mask
);

    logic               r_valid;
    logic [SRAM_AW-1:0] r_addr;
    logic [7:0]         r_strb;
    logic [63:0]        r_data;

    // A load wins over a coincident commit: the commit has already used the old contents.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_strb  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_load_addr;
            r_strb  <= i_load_strb;
            r_data  <= i_load_data;
        end else if (i_commit) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_addr     = r_addr;
    assign o_strb     = r_strb;
    assign o_data     = r_data;
    assign o_fwd_mask = (r_valid && (r_addr == i_rd_addr)) ? r_strb : 8'h00;

endmodule

// File: rtl/ahb_sram_4kx64_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a 4Kx64 SRAM: reads go straight to the
// array, writes are posted through a one-word buffer and forwarded to later reads.
module ahb_sram_4kx64_ctrl
    import aha_ahb_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESETn,
    ahb_sram_4kx64_ctrl_if.slave   s_ahb,
    output logic                   SRAM_CEn,
    output logic [7:0]             SRAM_WEn,
    output logic [SRAM_AW-1:0]     SRAM_A,
    output logic [63:0]            SRAM_D,
    input  logic [63:0]            SRAM_Q
);

    logic               w_accept, w_rd_acc, w_wr_acc, w_commit;
    logic [SRAM_AW-1:0] w_word_addr;
    logic               w_buf_valid;
    logic [SRAM_AW-1:0] w_buf_addr;
    logic [7:0]         w_buf_strb, w_fwd_mask;
    logic [63:0]        w_buf_data, w_rdata;

    logic               r_rd_phase, r_wr_phase;
    logic [SRAM_AW-1:0] r_rd_addr, r_wr_addr;
    logic [7:0]         r_wr_strb;

    // NOTE: RESETn gates acceptance so the SRAM stays deselected while reset is held,
    // even with a read request parked on the bus.
    assign w_accept = RESETn & s_ahb.HSEL & s_ahb.HREADY &
                      ((htrans_e'(s_ahb.HTRANS) == HTRANS_NONSEQ) ||
                       (htrans_e'(s_ahb.HTRANS) == HTRANS_SEQ));
    assign w_rd_acc    = w_accept & ~s_ahb.HWRITE;
    assign w_wr_acc    = w_accept &  s_ahb.HWRITE;
    assign w_word_addr = s_ahb.HADDR[ADDR_WIDTH-1:3];
    assign w_commit    = w_buf_valid & ~w_rd_acc;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_rd_phase <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_phase <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_strb  <= '0;
        end else begin
            r_rd_phase <= w_rd_acc;
            r_wr_phase <= w_wr_acc;
            if (w_rd_acc) r_rd_addr <= w_word_addr;
            if (w_wr_acc) begin
                r_wr_addr <= w_word_addr;
                r_wr_strb <= ahb_byte_strb(s_ahb.HSIZE, s_ahb.HADDR[2:0]);
            end
        end
    end

    ahb_sram_wbuf u_wbuf (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .i_load      (r_wr_phase),
        .i_load_addr (r_wr_addr),
        .i_load_strb (r_wr_strb),
        .i_load_data (s_ahb.HWDATA),
        .i_commit    (w_commit),
        .i_rd_addr   (r_rd_addr),
        .o_valid     (w_buf_valid),
        .o_addr      (w_buf_addr),
        .o_strb      (w_buf_strb),
        .o_data      (w_buf_data),
        .o_fwd_mask  (w_fwd_mask)
    );

    // Reads own the port; the buffer drains in any cycle without a read address phase.
    always_comb begin
        SRAM_CEn = 1'b1;
        SRAM_WEn = 8'hFF;
        SRAM_A   = w_buf_addr;
        if (w_rd_acc) begin
            SRAM_CEn = 1'b0;
            SRAM_A   = w_word_addr;
        end else if (w_buf_valid) begin
            SRAM_CEn = 1'b0;
            SRAM_WEn = ~w_buf_strb;
        end
    end

    assign SRAM_D = w_buf_data;

    always_comb begin
        w_rdata = '0;
        if (r_rd_phase) begin
            for (int i = 0; i < 8; i++) begin
                w_rdata[8*i +: 8] = w_fwd_mask[i] ? w_buf_data[8*i +: 8] : SRAM_Q[8*i +: 8];
            end
        end
    end

    assign s_ahb.HRDATA    = w_rdata;
    assign s_ahb.HREADYOUT = 1'b1;
    assign s_ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_sram_4kx64_ctrl.sv
// Directed bench for ahb_sram_4kx64_ctrl with a behavioural 4Kx64 SRAM model;
// inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_ahb_sram_4kx64_ctrl;
    import aha_ahb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        SRAM_CEn;
    logic [7:0]  SRAM_WEn;
    logic [11:0] SRAM_A;
    logic [63:0] SRAM_D;
    logic [63:0] SRAM_Q = '0;
    logic [63:0] mem [0:4095] = '{default: '0};
    int          n_sram_wr = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    ahb_sram_4kx64_ctrl_if ahb ();

    ahb_sram_4kx64_ctrl dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .s_ahb    (ahb.slave),
        .SRAM_CEn (SRAM_CEn),
        .SRAM_WEn (SRAM_WEn),
        .SRAM_A   (SRAM_A),
        .SRAM_D   (SRAM_D),
        .SRAM_Q   (SRAM_Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: read data appears the cycle after the access.
    always @(posedge CLK) begin
        if (!SRAM_CEn) begin
            if (&SRAM_WEn) begin
                SRAM_Q <= mem[SRAM_A];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (!SRAM_WEn[b]) mem[SRAM_A][8*b +: 8] <= SRAM_D[8*b +: 8];
                n_sram_wr <= n_sram_wr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ap(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [14:0] addr);
        ahb.HSEL   = sel;
        ahb.HTRANS = trans;
        ahb.HWRITE = wr;
        ahb.HSIZE  = size;
        ahb.HADDR  = addr;
        ahb.HREADY = 1'b1;
    endtask

    task automatic idle();
        ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 15'h0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [14:0] s_addr [4];
    logic [63:0] s_data [4];
    int          wr_before;

    initial begin
        s_addr[0] = 15'h0100; s_data[0] = 64'h0123456789ABCDEF;
        s_addr[1] = 15'h0208; s_data[1] = 64'hFEDCBA9876543210;
        s_addr[2] = 15'h03F0; s_data[2] = 64'hA5A5A5A55A5A5A5A;
        s_addr[3] = 15'h0450; s_data[3] = 64'h0F1E2D3C4B5A6978;

        // Reset with a read held on the bus
        RESETn     = 1'b0;
        ahb.HWDATA = '0;
        ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 15'h0010);
        for (int i = 0; i < 2; i++) begin
            mid();
            check("rst_cen",    SRAM_CEn,      1);
            check("rst_hrdata", ahb.HRDATA,    0);
            check("rst_ready",  ahb.HREADYOUT, 1);
            check("rst_hresp",  ahb.HRESP,     0);
            check("rst_wen",    SRAM_WEn,      8'hFF);
            check("rst_a",      SRAM_A,        0);
        end
        tick();
        RESETn = 1'b1;
        mid();
        check("rel_rd_cen", SRAM_CEn, 0);
        check("rel_rd_a",   SRAM_A,   12'h002);
        check("rel_rd_wen", SRAM_WEn, 8'hFF);
        tick(); idle();
        mid();
        check("rel_rd_data", ahb.HRDATA, 0);

        // Dword write, commit two cycles after the address phase
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 15'h0010);
        mid(); check("dw_ap_cen", SRAM_CEn, 1);
        tick(); idle(); ahb.HWDATA = 64'h1122334455667788;
        mid(); check("dw_dp_cen", SRAM_CEn, 1);
        tick();
        mid();
        check("dw_cmt_cen", SRAM_CEn, 0);
        check("dw_cmt_a",   SRAM_A,   12'h002);
        check("dw_cmt_wen", SRAM_WEn, 8'h00);
        check("dw_cmt_d",   SRAM_D,   64'h1122334455667788);
        tick();
        mid(); check("dw_drained", SRAM_CEn, 1);
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 15'h0010);
        mid(); check("dw_rd_a", SRAM_A, 12'h002);
        tick(); idle();
        mid(); check("dw_rd_data", ahb.HRDATA, 64'h1122334455667788);

        // Byte write then immediate read of the same word: forwarding
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 15'h0013);
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 15'h0010);
        ahb.HWDATA = 64'hFFFFFFFFABFFFFFF;
        mid();
        check("bw_rd_cen", SRAM_CEn, 0);
        check("bw_rd_wen", SRAM_WEn, 8'hFF);
        tick(); idle();
        mid();
        check("bw_fwd_data", ahb.HRDATA, 64'h11223344AB667788);
        check("bw_cmt_wen",  SRAM_WEn,   8'hF7);
        check("bw_cmt_a",    SRAM_A,     12'h002);
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 15'h0010);
        tick(); idle();
        mid(); check("bw_mem_data", ahb.HRDATA, 64'h11223344AB667788);

        // Streaming W/R/W/R at four addresses
        for (int i = 0; i < 4; i++) begin
            tick(); ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_DWORD, s_addr[i]);
            mid();
            check("st_ready", ahb.HREADYOUT, 1);
            if (i > 0) begin
                check("st_rd_data", ahb.HRDATA, s_data[i-1]);
                check("st_cmt_a",   SRAM_A,     {3'b0, s_addr[i-1][14:3]});
                check("st_cmt_wen", SRAM_WEn,   8'h00);
            end
            tick(); ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_DWORD, s_addr[i]);
            ahb.HWDATA = s_data[i];
            mid();
            check("st_rd_a",   SRAM_A,   {3'b0, s_addr[i][14:3]});
            check("st_rd_wen", SRAM_WEn, 8'hFF);
        end
        tick(); idle();
        mid();
        check("st_rd_last",  ahb.HRDATA, s_data[3]);
        check("st_cmt_last", SRAM_A,     {3'b0, s_addr[3][14:3]});
        for (int i = 0; i < 4; i++) begin
            tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, s_addr[i]);
            mid();
            if (i > 0) check("st_readback", ahb.HRDATA, s_data[i-1]);
        end
        tick(); idle();
        mid(); check("st_readback", ahb.HRDATA, s_data[3]);

        // Halfword at the top of the window
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 15'h7FFE);
        tick(); idle(); ahb.HWDATA = 64'hBEEF123456789ABC;
        tick();
        mid();
        check("hw_cmt_a",   SRAM_A,   12'hFFF);
        check("hw_cmt_wen", SRAM_WEn, 8'h3F);
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 15'h7FFE);
        mid(); check("hw_rd_a", SRAM_A, 12'hFFF);
        tick(); idle();
        mid(); check("hw_rd_data", ahb.HRDATA, 64'hBEEF000000000000);

        // Reset during a write data phase discards the write
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 15'h0010);
        wr_before = n_sram_wr;
        tick(); idle(); ahb.HWDATA = 64'hCAFEF00DCAFEF00D;
        RESETn = 1'b0;
        mid(); check("rw_rst_cen", SRAM_CEn, 1);
        tick(); RESETn = 1'b1;
        mid(); check("rw_rel_cen", SRAM_CEn, 1);
        tick();
        mid(); check("rw_idle_cen", SRAM_CEn, 1);
        check("rw_no_write", 64'(n_sram_wr), 64'(wr_before));
        tick(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 15'h0010);
        tick(); idle();
        mid(); check("rw_mem_kept", ahb.HRDATA, 64'h11223344AB667788);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ahb_sram_4kx64_ctrl.md
# ahb_sram_4kx64_ctrl

Zero-wait-state AHB-Lite slave that fronts the 4K×64 (32 KB) GF SRAM wrapper, driving its active-low chip enable, per-byte active-low write enables, 12-bit word address and 64-bit data. It sits directly upstream of the SRAM wrapper. Writes go through a single-entry write buffer, and buffered bytes are forwarded to reads, so every transfer completes with HREADYOUT=1.

## Interface
- ADDR_WIDTH, 15, AHB byte-address bits used (32 KB window); SRAM word address = HADDR[14:3]
- CLK  in  1  clock
- RESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HREADY  in  1  bus ready (address phase accepted when high)
- HWDATA  in  64  write data (data phase)
- HREADYOUT  out  1  always 1
- HRESP  out  1  always 0 (OKAY)
- HRDATA  out  64  read data (data phase)
- SRAM_CEn  out  1  SRAM chip enable, active low
- SRAM_WEn  out  8  per-byte write enable, active low; all ones = read
- SRAM_A  out  12  SRAM word address
- SRAM_D  out  64  SRAM write data
- SRAM_Q  in  64  SRAM read data, valid the cycle after a read access

## Operation
- Accepted transfer: HSEL & HREADY & HTRANS[1].
- Byte strobe, 8 bits, from HSIZE and HADDR[2:0]:
  - size 0: one byte at HADDR[2:0]
  - size 1: two bytes at {HADDR[2:1],0}
  - size 2: four bytes at {HADDR[2],00}
  - size ≥3: all eight bytes
- Accepted read: SRAM read issued in the same cycle.
  - SRAM_CEn=0, SRAM_WEn=8'hFF, SRAM_A=HADDR[14:3].
  - The read's word address is registered for its data phase.
- Accepted write: word address and strobe are registered; no SRAM access in the address phase.
  - At the end of the data phase, HWDATA, address and strobe load the write buffer; buf_valid=1.
- SRAM port priority in each cycle:
  1. Accepted read address phase.
  2. Otherwise, if buf_valid: commit the buffer (SRAM_CEn=0, SRAM_WEn=~buf_strb, SRAM_A=buf_addr, SRAM_D=buf_data). buf_valid clears at the end of that cycle unless a new write data phase reloads the buffer.
  3. Otherwise idle: SRAM_CEn=1, SRAM_WEn=8'hFF.
- Single entry is sufficient. Any write's address phase leaves the SRAM free, so a pending buffer always commits before the next write's data lands. If a load and a commit coincide, the commit uses the old contents and the buffer then holds the new data.
- Read data phase: HRDATA = SRAM_Q, with each byte i replaced by buf_data byte i when buf_valid & buf_addr==rd_addr & buf_strb[i]. This compare uses current buffer state, including a write captured in the preceding cycle or being committed this cycle.
- Outside a read data phase, HRDATA=0.
- SRAM_D = buf_data at all times; masked bytes are don't-care.

## Timing
- Reset values:
  - buf_valid=0, buf_addr=0, buf_strb=0, buf_data=0, read-data-phase flag=0.
  - HRDATA=0, HREADYOUT=1, HRESP=0, SRAM_CEn=1, SRAM_WEn=8'hFF, SRAM_A=0.
- While RESETn=0, SRAM_CEn is forced to 1.
- Reset mid-operation: a pending buffered write is discarded, not committed.
- Read latency: address phase at N, SRAM access at N, HRDATA valid at N+1 (zero wait).
- Write: address phase at N, data at N+1, earliest commit at N+2. The commit is deferred by back-to-back reads and occurs no later than the next write's address phase.
- HSEL low, HTRANS IDLE/BUSY, or HREADY low: no new access, and the buffer may commit.

## Structure
- Shared package aha_ahb_pkg holds the HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE codes and the strobe-generation function.
- One sub-module, ahb_sram_wbuf, holds the single-entry buffer (valid, addr, strb, data) and exposes a per-byte forwarding mask for a given read address.
- The top level contains the address-phase decode, the SRAM port mux and the HRDATA merge.

## Test plan
- Reset with HSEL=1, NONSEQ, read held: SRAM_CEn=1, HRDATA=0, HREADYOUT=1 until release; first read accepted after release.
- Dword write of 0x1122334455667788 to 0x0010, then IDLE: commit at N+2 with SRAM_A=0x002 and SRAM_WEn=8'h00; a later read returns the same value.
- Byte write of 0xAB to 0x0013, then immediate read of 0x0010 (memory holds 0x1122334455667788): HRDATA=0x11223344AB667788 via forwarding; SRAM_WEn=8'hF7 at the commit.
- Alternating W/R/W/R streaming at four different addresses: HREADYOUT=1 throughout, each write committed before the next write's data phase, all read-backs correct.
- Halfword write to 0x7FFE (top of window), then a read: SRAM_A=0xFFF, SRAM_WEn=8'h3F, data correct.
- Write address phase, then RESETn asserted during its data phase: no SRAM write occurs and buf_valid=0 after release.
